// File: rtl/dsa_mem_pkg.sv
// Shared memory-map constants and types for the downscaler memory responder.
// The base addresses are also used by main_controller, so keep them in step.
package dsa_mem_pkg;

  localparam logic [15:0] INPUT_BASE_ADDR  = 16'd0;
  localparam logic [15:0] OUTPUT_BASE_ADDR = 16'd16384;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic {H_IDLE, H_ACK} host_state_t;

endpackage

// File: rtl/mem_bank_be.sv
// Single-port DEPTH x 32 RAM with byte-lane write enables and a registered read port.
// No reset on storage or read register, so it maps onto block RAM.
module mem_bank_be
  import dsa_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 32768,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read-before-write: rdata_q samples the old word on a same-address write.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we_i[l]) begin
        mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_mem_responder.sv
// Memory responder for the downscaler: engine port with 1-cycle reads, plus a host
// load/readback port that borrows the single RAM port while the engine is idle.
module image_mem_responder
  import dsa_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_eng_busy,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_byte_en,
  input  logic [31:0]       i_mem_wdata,
  output logic [31:0]       o_mem_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [3:0]        i_host_byte_en,
  input  logic [31:0]       i_host_wdata,
  output logic              o_host_ack,
  output logic [31:0]       o_host_rdata,
  input  logic              i_clr_stats,
  output logic [CNT_W-1:0]  o_wr_count,
  output logic              o_oob_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  host_state_t state_q, state_d;
  logic        host_we_q, host_we_d;
  logic        zero_q;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic        oob_err_q, oob_err_d;

  logic              host_grant;
  logic              port_access;
  logic [ADDR_W-1:0] port_addr;
  logic              port_we;
  logic [3:0]        port_be;
  logic [31:0]       port_wdata;
  logic              port_oob;
  logic [3:0]        bank_we;
  logic [31:0]       bank_rdata;

  assign host_grant  = !i_eng_busy && (state_q == H_IDLE) && i_host_req;
  assign port_access = i_eng_busy || host_grant;

  always_comb begin
    port_addr  = i_mem_addr;
    port_we    = 1'b0;
    port_be    = i_mem_byte_en;
    port_wdata = i_mem_wdata;
    if (i_eng_busy) begin
      port_we = i_mem_we;
    end else if (host_grant) begin
      port_addr  = i_host_addr;
      port_we    = i_host_we;
      port_be    = i_host_byte_en;
      port_wdata = i_host_wdata;
    end
  end

  assign port_oob = 32'(port_addr) >= DEPTH;
  // Writes are suppressed out of range and while reset is held.
  assign bank_we  = (port_oob || !rst_n || !port_we) ? 4'b0000 : port_be;

  mem_bank_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk_i   (clk),
    .addr_i  (port_addr[AW-1:0]),
    .we_i    (bank_we),
    .wdata_i (port_wdata),
    .rdata_o (bank_rdata)
  );

  // The bank read register has no reset; zero_q masks it after reset and for OOB reads.
  assign o_mem_rdata = zero_q ? 32'h0 : bank_rdata;

  always_comb begin
    state_d   = state_q;
    host_we_d = host_we_q;
    unique case (state_q)
      H_IDLE: begin
        if (host_grant) begin
          state_d   = H_ACK;
          host_we_d = i_host_we;
        end
      end
      H_ACK:   state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  assign o_host_ack   = (state_q == H_ACK);
  assign o_host_rdata = (o_host_ack && !host_we_q) ? o_mem_rdata : 32'h0;

  always_comb begin
    wr_count_d = wr_count_q;
    oob_err_d  = oob_err_q;
    if (i_clr_stats) begin
      wr_count_d = '0;
      oob_err_d  = 1'b0;
    end else begin
      if (i_eng_busy && i_mem_we && (i_mem_byte_en != 4'b0000) && (wr_count_q != '1)) begin
        wr_count_d = wr_count_q + 1'b1;
      end
      if (port_access && port_oob) begin
        oob_err_d = 1'b1;
      end
    end
  end

  assign o_wr_count = wr_count_q;
  assign o_oob_err  = oob_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= H_IDLE;
      host_we_q  <= 1'b0;
      zero_q     <= 1'b1;
      wr_count_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      host_we_q  <= host_we_d;
      zero_q     <= port_oob;
      wr_count_q <= wr_count_d;
      oob_err_q  <= oob_err_d;
    end
  end

endmodule
